// File: rtl/suma_seq_ctrl_if.sv
// rtl/suma_seq_ctrl_if.sv - operand stream and shared Suma adder bus for suma_seq_ctrl
interface suma_seq_ctrl_if #(
    parameter int SIZE = 5
);
    logic              in_valid;
    logic [SIZE+2:0]   in_data;
    logic              in_ready;
    logic [SIZE+2:0]   add_a;
    logic [SIZE+2:0]   add_b;
    logic [SIZE+3:0]   add_sum;

    modport master (
        output in_valid, in_data, add_sum,
        input  in_ready, add_a, add_b
    );

    modport slave (
        input  in_valid, in_data, add_sum,
        output in_ready, add_a, add_b
    );
endinterface

// File: rtl/suma_seq_ctrl.sv
// rtl/suma_seq_ctrl.sv - sequences one shared Suma adder to accumulate N_TERMS operands with saturation
module suma_seq_ctrl #(
    parameter int SIZE    = 5,
    parameter int N_TERMS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    suma_seq_ctrl_if.slave  bus,
    output logic [SIZE+2:0] result,
    output logic            overflow,
    output logic            done,
    output logic            busy
);
    localparam int W     = SIZE + 3;
    localparam int CNT_W = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t           state;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             in_ready_q;

    logic             hs;
    logic             next_ovf;
    logic [W-1:0]     next_acc;

    // Saturation is sticky: once set, the adder output is ignored for the rest of the run.
    always_comb begin
        hs       = bus.in_valid & in_ready_q;
        next_ovf = ovf | bus.add_sum[W];
        next_acc = next_ovf ? '1 : bus.add_sum[W-1:0];
    end

    assign bus.in_ready = in_ready_q;
    assign bus.add_a    = in_ready_q ? acc         : '0;
    assign bus.add_b    = in_ready_q ? bus.in_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            in_ready_q <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_ACC;
                        acc        <= '0;
                        cnt        <= '0;
                        ovf        <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (hs) begin
                        acc <= next_acc;
                        ovf <= next_ovf;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state      <= S_DONE;
                            in_ready_q <= 1'b0;
                            done       <= 1'b1;
                            result     <= next_acc;
                            overflow   <= next_ovf;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    in_ready_q <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule
